// File: rtl/spi_burst_ctrl.sv
// ============================================================================
// Module  : spi_burst_ctrl
// Brief   : Multi-byte SPI burst sequencer driving a byte-level SPI master.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_burst_ctrl #(
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             done,
  output logic             cs_n,
  output logic             spi_start,
  output logic [7:0]       spi_data_in,
  input  logic             spi_busy,
  input  logic             spi_new_data,
  input  logic [7:0]       spi_data_out
);

  localparam int c_cnt_max = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  // FETCH supplies the last setup cycle, so SETUP itself runs CS_SETUP-1 cycles.
  localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(CS_SETUP - 2);
  localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_XFER   = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_cs_n;
  logic               r_spi_start;
  logic [7:0]         r_spi_data_in;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_remaining   <= '0;
      r_cs_n        <= 1'b1;
      r_spi_start   <= 1'b0;
      r_spi_data_in <= 8'h00;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_spi_start <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_remaining <= cmd_len;
            r_cnt       <= '0;
            if (cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_cs_n  <= 1'b0;
              r_state <= (CS_SETUP <= 1) ? ST_FETCH : ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (r_cnt == c_setup_last) begin
            r_cnt   <= '0;
            r_state <= ST_FETCH;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        ST_FETCH: begin
          if (tx_valid) begin
            r_spi_data_in <= tx_data;
            r_spi_start   <= !spi_busy;
            r_state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // A busy master on entry defers the pulse until it goes idle.
          if (r_spi_start) begin
            r_state <= ST_XFER;
          end else if (!spi_busy) begin
            r_spi_start <= 1'b1;
          end
        end
        ST_XFER: begin
          if (spi_new_data) begin
            r_rx_data  <= spi_data_out;
            r_rx_valid <= 1'b1;
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - LEN_W'(1);
            end
            if (r_remaining <= LEN_W'(1)) begin
              r_cnt   <= '0;
              r_state <= ST_HOLD;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_HOLD: begin
          if (r_cnt == c_hold_last) begin
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign tx_ready    = (r_state == ST_FETCH);
  assign cs_n        = r_cs_n;
  assign spi_start   = r_spi_start;
  assign spi_data_in = r_spi_data_in;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_burst_ctrl.sv
// ============================================================================
// Module  : tb_spi_burst_ctrl
// Brief   : Directed self-checking bench for spi_burst_ctrl with an SPI master model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_burst_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       done;
  logic       cs_n;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic       spi_busy;
  logic       spi_new_data;
  logic [7:0] spi_data_out;

  spi_burst_ctrl #(.LEN_W(8), .CS_SETUP(4), .CS_HOLD(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .done         (done),
    .cs_n         (cs_n),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_new_data (spi_new_data),
    .spi_data_out (spi_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event logs, all indexed by the negedge cycle count.
  int         cyc = 0;
  int         acc_q[$], fall_q[$], rise_q[$], start_q[$], rxc_q[$], done_q[$];
  logic [7:0] sdata_q[$], rxd_q[$], tx_q[$], resp_q[$];
  int         txr_cnt, stall_cnt, pops, stall_at, hold;
  bit         tx_pop_req;
  bit         prev_cs = 1'b1;

  task automatic clear_logs();
    acc_q.delete(); fall_q.delete(); rise_q.delete(); start_q.delete();
    rxc_q.delete(); done_q.delete(); sdata_q.delete(); rxd_q.delete();
    txr_cnt = 0; stall_cnt = 0; pops = 0;
  endtask

  // Monitor: outputs and inputs are both stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (prev_cs && !cs_n) fall_q.push_back(cyc);
        if (!prev_cs && cs_n) rise_q.push_back(cyc);
        if (spi_start) begin start_q.push_back(cyc); sdata_q.push_back(spi_data_in); end
        if (rx_valid) begin rxc_q.push_back(cyc); rxd_q.push_back(rx_data); end
        if (done) done_q.push_back(cyc);
        if (tx_ready) txr_cnt++;
        if (tx_ready && !tx_valid) stall_cnt++;
        if (tx_ready && tx_valid) tx_pop_req = 1'b1;
      end
      prev_cs = cs_n;
    end
  end

  // TX stream source; stall_at selects after which pop a 10-cycle gap is inserted.
  initial begin
    tx_valid = 1'b0; tx_data = 8'h00; hold = 0; stall_at = 0; tx_pop_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_pop_req) begin
        tx_pop_req = 1'b0;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
        pops++;
        if (pops == stall_at) hold = 10;
      end else if (hold > 0) begin
        hold--;
      end
      tx_valid = (tx_q.size() > 0) && (hold == 0) && !rst;
      tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  // SPI master model: busy for 5 cycles, then new_data with the queued reply or ~byte.
  logic [7:0] m_byte;
  int         m_cnt;
  initial begin
    spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = 8'h00; m_cnt = 0; m_byte = 8'h00;
    forever begin
      @(posedge clk); #1;
      spi_new_data = 1'b0;
      if (rst) begin
        spi_busy = 1'b0;
        m_cnt    = 0;
      end else if (spi_start && !spi_busy) begin
        m_byte   = spi_data_in;
        m_cnt    = 4;
        spi_busy = 1'b1;
      end else if (spi_busy) begin
        if (m_cnt == 0) begin
          spi_busy     = 1'b0;
          spi_new_data = 1'b1;
          if (resp_q.size() > 0) spi_data_out = resp_q.pop_front();
          else spi_data_out = ~m_byte;
        end else begin
          m_cnt--;
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] len);
    int n0 = acc_q.size();
    int b  = 0;
    @(posedge clk); #1;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (acc_q.size() == n0 && b < 100) begin @(negedge clk); #1; b++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_accept_timeout", 32'(acc_q.size() > n0), 32'd1);
  endtask

  task automatic wait_done(input int n);
    int b = 0;
    while (done_q.size() < n && b < 400) begin @(negedge clk); #1; b++; end
    check("done_timeout", 32'(done_q.size() >= n), 32'd1);
  endtask

  task automatic wait_starts(input int n);
    int b = 0;
    while (start_q.size() < n && b < 400) begin @(negedge clk); #1; b++; end
    check("start_timeout", 32'(start_q.size() >= n), 32'd1);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
    clear_logs();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = 8'h00;
    clear_logs();
    #1;
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    settle();

    // Single byte: echo of 0xA5 comes back as 0x5A.
    tx_q.push_back(8'hA5);
    send_cmd(8'd1);
    wait_done(1);
    check("t1_cs_fall_lat", 32'(fall_q[0] - acc_q[0]), 32'd1);
    check("t1_start_lat", 32'(start_q[0] - fall_q[0]), 32'd4);
    check("t1_start_cnt", 32'(start_q.size()), 32'd1);
    check("t1_spi_data_in", 32'(sdata_q[0]), 32'hA5);
    check("t1_rx_data", 32'(rxd_q[0]), 32'h5A);
    check("t1_done_lat", 32'(done_q[0] - rxc_q[0]), 32'd4);
    check("t1_cs_rise_eq_done", 32'(rise_q[0]), 32'(done_q[0]));
    settle();

    // Three bytes back to back.
    tx_q = '{8'h11, 8'h22, 8'h33};
    resp_q = '{8'h81, 8'h82, 8'h83};
    send_cmd(8'd3);
    wait_done(1);
    check("t2_start_cnt", 32'(start_q.size()), 32'd3);
    check("t2_tx_order", {8'h0, sdata_q[0], sdata_q[1], sdata_q[2]}, 32'h00112233);
    check("t2_rx_cnt", 32'(rxd_q.size()), 32'd3);
    check("t2_rx_order", {8'h0, rxd_q[0], rxd_q[1], rxd_q[2]}, 32'h00818283);
    check("t2_cs_windows", 32'(fall_q.size() * 16 + rise_q.size()), 32'h11);
    check("t2_byte_gap", 32'(start_q[1] - start_q[0]), 32'd7);
    repeat (6) @(negedge clk);
    #1;
    check("t2_done_cnt", 32'(done_q.size()), 32'd1);
    settle();

    // Three bytes with a 10-cycle TX gap after the first byte.
    tx_q = '{8'h11, 8'h22, 8'h33};
    resp_q = '{8'h81, 8'h82, 8'h83};
    stall_at = 1;
    send_cmd(8'd3);
    wait_done(1);
    stall_at = 0;
    check("t3_stall_cycles", 32'(stall_cnt), 32'd4);
    check("t3_byte_gap", 32'(start_q[1] - start_q[0]), 32'd11);
    check("t3_cs_windows", 32'(fall_q.size() * 16 + rise_q.size()), 32'h11);
    check("t3_rx_order", {8'h0, rxd_q[0], rxd_q[1], rxd_q[2]}, 32'h00818283);
    check("t3_tx_order", {8'h0, sdata_q[0], sdata_q[1], sdata_q[2]}, 32'h00112233);
    settle();

    // Zero-length command.
    send_cmd(8'd0);
    repeat (6) @(negedge clk);
    #1;
    check("t4_done_cnt", 32'(done_q.size()), 32'd1);
    check("t4_done_lat", 32'(done_q[0] - acc_q[0]), 32'd1);
    check("t4_cs_fall_cnt", 32'(fall_q.size()), 32'd0);
    check("t4_start_cnt", 32'(start_q.size()), 32'd0);
    check("t4_tx_ready_cnt", 32'(txr_cnt), 32'd0);
    settle();

    // Asynchronous reset in the middle of byte 2 of 4.
    tx_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    send_cmd(8'd4);
    wait_starts(2);
    @(negedge clk); #2;
    check("t5_cs_before_rst", 32'(cs_n), 32'd0);
    rst = 1'b1;
    #1;
    check("t5_cs_n", 32'(cs_n), 32'd1);
    check("t5_outputs", {25'h0, spi_start, rx_valid, done, tx_ready, cmd_ready, 2'b00}, 32'h4);
    check("t5_spi_data_in", 32'(spi_data_in), 32'h00);
    check("t5_rx_data", 32'(rx_data), 32'h00);
    tx_q.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold = 0;
    settle();
    check("t5_cmd_ready_after", 32'(cmd_ready), 32'd1);
    tx_q.push_back(8'h3C);
    send_cmd(8'd1);
    wait_done(1);
    check("t5_post_start_cnt", 32'(start_q.size()), 32'd1);
    check("t5_post_tx", 32'(sdata_q[0]), 32'h3C);
    check("t5_post_rx", 32'(rxd_q[0]), 32'hC3);
    settle();

    // Back-to-back commands with cmd_valid held high.
    tx_q = '{8'h01, 8'h02, 8'h03};
    begin
      int b = 0;
      @(posedge clk); #1;
      cmd_len = 8'd2; cmd_valid = 1'b1;
      while (acc_q.size() < 1 && b < 100) begin @(negedge clk); #1; b++; end
      @(posedge clk); #1;
      cmd_len = 8'd1;
      while (acc_q.size() < 2 && b < 400) begin @(negedge clk); #1; b++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("t6_accept_timeout", 32'(acc_q.size()), 32'd2);
    end
    wait_done(2);
    check("t6_second_accept_at_done", 32'(acc_q[1]), 32'(done_q[0]));
    check("t6_cs_high_gap", 32'(fall_q[1] - rise_q[0]), 32'd1);
    check("t6_start_cnt", 32'(start_q.size()), 32'd3);
    check("t6_rx_order", {8'h0, rxd_q[0], rxd_q[1], rxd_q[2]}, 32'h00FEFDFC);
    repeat (6) @(negedge clk);
    #1;
    check("t6_accept_cnt", 32'(acc_q.size()), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
